// File: rtl/positaddsub_pipe_raw.sv
// positaddsub_pipe_raw: four-stage add/subtract of two decoded posit values.
// Produces an unrounded raw sum {sgn, scale, fraction, inf, zero} and a
// sticky truncated flag; posit encoding and rounding happen downstream.
// The whole pipeline advances together and holds when the consumer stalls.
module positaddsub_pipe_raw #(
  parameter int SW = 9,
  parameter int FW = 26,
  parameter int GB = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op_sub,
  input  logic [SW+FW+2:0]    in1,
  input  logic [SW+FW+2:0]    in2,
  input  logic                in1_truncated,
  input  logic                in2_truncated,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SW+FW+GB+4:0] result,
  output logic                truncated
);

  localparam int AB  = FW + GB + 1;
  localparam int OW  = SW + AB + 4;
  localparam int LSW = $clog2(AB + 1);
  localparam logic [SW:0]        SAT_LIM = (SW+1)'(2 * AB);
  localparam logic signed [SW:0] ONE_S   = (SW+1)'(1);

  // Alignment shift saturates once the whole low mantissa has been pushed out.
  function automatic logic [SW:0] sat_shift(input logic [SW:0] d);
    return (d > SAT_LIM) ? SAT_LIM : d;
  endfunction

  // Left shift that moves the leading one of the sum to bit AB (0 for a zero sum).
  function automatic logic [LSW-1:0] norm_shift(input logic [AB:0] s);
    logic [LSW-1:0] n;
    n = '0;
    for (int i = 0; i <= AB; i++) begin
      if (s[i]) n = LSW'(AB - i);
    end
    return n;
  endfunction

  logic w_adv;
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  // ---------------- S0: decode, zero forcing, magnitude compare ----------------
  logic                 w_a_sgn, w_a_inf, w_a_zero, w_a_tr;
  logic                 w_b_sgn, w_b_inf, w_b_zero, w_b_tr;
  logic signed [SW-1:0] w_a_scale, w_b_scale;
  logic [FW-1:0]        w_a_frac, w_b_frac;
  logic                 w_b_gt;
  logic                 w_hi_sgn, w_hi_zero, w_lo_zero;
  logic signed [SW-1:0] w_hi_scale, w_lo_scale;
  logic [FW-1:0]        w_hi_frac, w_lo_frac;
  logic [SW:0]          w_diff;

  // Decode operands, pick the larger magnitude (ties go to in1) and the scale gap.
  always_comb begin
    w_a_zero  = in1[0];
    w_a_inf   = in1[1] & ~w_a_zero;
    w_a_frac  = w_a_zero ? '0 : in1[FW+1:2];
    w_a_scale = w_a_zero ? '0 : in1[SW+FW+1:FW+2];
    w_a_sgn   = in1[SW+FW+2] & ~w_a_zero;
    w_a_tr    = in1_truncated & ~w_a_zero;
    w_b_zero  = in2[0];
    w_b_inf   = in2[1] & ~w_b_zero;
    w_b_frac  = w_b_zero ? '0 : in2[FW+1:2];
    w_b_scale = w_b_zero ? '0 : in2[SW+FW+1:FW+2];
    w_b_sgn   = (in2[SW+FW+2] ^ op_sub) & ~w_b_zero;
    w_b_tr    = in2_truncated & ~w_b_zero;
    if (w_a_zero)                    w_b_gt = ~w_b_zero;
    else if (w_b_zero)               w_b_gt = 1'b0;
    else if (w_a_scale != w_b_scale) w_b_gt = (w_b_scale > w_a_scale);
    else                             w_b_gt = (w_b_frac > w_a_frac);
    if (w_b_gt) begin
      w_hi_sgn = w_b_sgn; w_hi_scale = w_b_scale; w_hi_frac = w_b_frac; w_hi_zero = w_b_zero;
      w_lo_scale = w_a_scale; w_lo_frac = w_a_frac; w_lo_zero = w_a_zero;
    end else begin
      w_hi_sgn = w_a_sgn; w_hi_scale = w_a_scale; w_hi_frac = w_a_frac; w_hi_zero = w_a_zero;
      w_lo_scale = w_b_scale; w_lo_frac = w_b_frac; w_lo_zero = w_b_zero;
    end
    w_diff = {w_hi_scale[SW-1], w_hi_scale} - {w_lo_scale[SW-1], w_lo_scale};
  end

  logic                 r_vld_p0;
  logic                 r_hi_sgn_p0, r_hi_zero_p0, r_lo_zero_p0, r_eff_add_p0, r_inf_p0, r_trin_p0;
  logic signed [SW-1:0] r_hi_scale_p0;
  logic [FW-1:0]        r_hi_frac_p0, r_lo_frac_p0;
  logic [SW:0]          r_diff_p0;

  // Stage 0 valid; cleared by reset.
  always_ff @(posedge clk) begin
    if (reset)      r_vld_p0 <= 1'b0;
    else if (w_adv) r_vld_p0 <= in_valid;
  end

  // Stage 0 data register.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_hi_sgn_p0   <= w_hi_sgn;
      r_hi_scale_p0 <= w_hi_scale;
      r_hi_frac_p0  <= w_hi_frac;
      r_hi_zero_p0  <= w_hi_zero;
      r_lo_frac_p0  <= w_lo_frac;
      r_lo_zero_p0  <= w_lo_zero;
      r_diff_p0     <= w_diff;
      r_eff_add_p0  <= w_a_sgn ~^ w_b_sgn;
      r_inf_p0      <= w_a_inf | w_b_inf;
      r_trin_p0     <= w_a_tr | w_b_tr;
    end
  end

  // ---------------- S1: align low operand, add/subtract, sticky ----------------
  logic [2*AB-1:0] w_lo_mant, w_lo_shf;
  logic [AB-1:0]   w_hi_mant;
  logic [AB:0]     w_sum;
  logic            w_sticky;

  // Shift the smaller operand into place; anything shifted out feeds the sticky.
  always_comb begin
    w_lo_mant = {~r_lo_zero_p0, r_lo_frac_p0, {GB{1'b0}}, {AB{1'b0}}};
    w_lo_shf  = w_lo_mant >> sat_shift(r_diff_p0);
    w_hi_mant = {~r_hi_zero_p0, r_hi_frac_p0, {GB{1'b0}}};
    w_sticky  = (|w_lo_shf[AB-1:0]) | ((r_diff_p0 >= SAT_LIM) & ~r_lo_zero_p0) | r_trin_p0;
    if (r_eff_add_p0) w_sum = {1'b0, w_hi_mant} + {1'b0, w_lo_shf[2*AB-1:AB]};
    else              w_sum = {1'b0, w_hi_mant} - {1'b0, w_lo_shf[2*AB-1:AB]};
  end

  logic                 r_vld_p1, r_sticky_p1, r_sgn_p1, r_inf_p1;
  logic [AB:0]          r_sum_p1;
  logic signed [SW-1:0] r_hi_scale_p1;

  // Stage 1 valid; cleared by reset.
  always_ff @(posedge clk) begin
    if (reset)      r_vld_p1 <= 1'b0;
    else if (w_adv) r_vld_p1 <= r_vld_p0;
  end

  // Stage 1 data register.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_sum_p1      <= w_sum;
      r_sticky_p1   <= w_sticky;
      r_hi_scale_p1 <= r_hi_scale_p0;
      r_sgn_p1      <= r_hi_sgn_p0;
      r_inf_p1      <= r_inf_p0;
    end
  end

  // ---------------- S2: leading-one detect, scale adjust ----------------
  logic [LSW-1:0]     w_lsh;
  logic signed [SW:0] w_hs, w_lx, w_scale;

  // Carry gives +1, leading one at AB-1 gives +0, lower positions subtract the gap.
  always_comb begin
    w_lsh   = norm_shift(r_sum_p1);
    w_hs    = {r_hi_scale_p1[SW-1], r_hi_scale_p1};
    w_lx    = {{(SW+1-LSW){1'b0}}, w_lsh};
    w_scale = w_hs - w_lx + ONE_S;
  end

  logic               r_vld_p2, r_sticky_p2, r_sgn_p2, r_inf_p2, r_zero_p2;
  logic [AB:0]        r_sum_p2;
  logic [LSW-1:0]     r_lsh_p2;
  logic signed [SW:0] r_scale_p2;

  // Stage 2 valid; cleared by reset.
  always_ff @(posedge clk) begin
    if (reset)      r_vld_p2 <= 1'b0;
    else if (w_adv) r_vld_p2 <= r_vld_p1;
  end

  // Stage 2 data register.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_sum_p2    <= r_sum_p1;
      r_lsh_p2    <= w_lsh;
      r_scale_p2  <= w_scale;
      r_sticky_p2 <= r_sticky_p1;
      r_sgn_p2    <= r_sgn_p1;
      r_inf_p2    <= r_inf_p1;
      r_zero_p2   <= (r_sum_p1 == '0);
    end
  end

  // ---------------- S3: normalise and format result ----------------
  logic [AB-1:0] w_frac;
  logic [OW-1:0] w_res;

  // Drop the hidden bit; inf wins over zero, exact cancellation gives +0.
  always_comb begin
    w_frac = AB'(r_sum_p2 << r_lsh_p2);
    if (r_inf_p2)       w_res = {r_sgn_p2, {(SW+1){1'b0}}, {AB{1'b0}}, 2'b10};
    else if (r_zero_p2) w_res = {{(OW-1){1'b0}}, 1'b1};
    else                w_res = {r_sgn_p2, r_scale_p2, w_frac, 2'b00};
  end

  logic          r_vld_p3, r_trunc_p3;
  logic [OW-1:0] r_result_p3;

  // Output register: holds under stall, loads only real results, zeroed by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p3    <= 1'b0;
      r_result_p3 <= '0;
      r_trunc_p3  <= 1'b0;
    end else if (w_adv) begin
      r_vld_p3 <= r_vld_p2;
      if (r_vld_p2) begin
        r_result_p3 <= w_res;
        r_trunc_p3  <= r_sticky_p2;
      end
    end
  end

  assign out_valid = r_vld_p3;
  assign result    = r_result_p3;
  assign truncated = r_trunc_p3;

endmodule
